// File: rtl/txpll_seq_pkg.sv
// Shared types and constants for the TX PLL lock sequencer.
// Optional loss counter is enabled with the TXPLL_SEQ_LOSS_CNT_EN macro.
package txpll_seq_pkg;

    localparam int SEQ_STATE_W = 3;
    localparam int LOSS_CNT_W  = 8;
    localparam logic [LOSS_CNT_W-1:0] LOSS_CNT_MAX = 8'd255;

    typedef enum logic [SEQ_STATE_W-1:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_QUALIFY   = 3'd2,
        ST_RELEASE   = 3'd3,
        ST_READY     = 3'd4,
        ST_FAULT     = 3'd5
    } seq_state_t;

endpackage

// File: rtl/txpll_lock_sync.sv
// Two-flop synchronizer bringing the PLL lock flag into the fabric clock.
// Both stages reset to 0 so a reset always looks like "not locked".
module txpll_lock_sync (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/txpll_lock_sequencer.sv
// TX PLL lock qualification and staggered lane reset release.
// Define TXPLL_SEQ_LOSS_CNT_EN to build the saturating lock-loss counter.
module txpll_lock_sequencer
    import txpll_seq_pkg::*;
#(
    parameter int NUM_LANES           = 4,
    parameter int LOCK_STABLE_CYCLES  = 1000,
    parameter int LOCK_TIMEOUT_CYCLES = 100000,
    parameter int LANE_STAGGER_CYCLES = 16,
    parameter int TMR_W               = 17
) (
    input  logic                   Clock,
    input  logic                   Reset,
    input  logic                   Enable,
    input  logic                   Retry,
    input  logic                   PLL_LOCK,
    output logic [NUM_LANES-1:0]   Lane_Reset,
    output logic                   Pll_Ready,
    output logic                   Lock_Timeout,
    output logic [SEQ_STATE_W-1:0] Seq_State,
    output logic [LOSS_CNT_W-1:0]  Loss_Count,
    input  logic                   Loss_Clear
);

    localparam int IDX_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_LANES - 1);
    localparam logic [TMR_W-1:0] TO_LAST  = TMR_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [TMR_W-1:0] QL_LAST  = TMR_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [TMR_W-1:0] STAG_LD  = TMR_W'(LANE_STAGGER_CYCLES - 1);
    localparam logic [NUM_LANES-1:0] ALL_RST = '1;

    seq_state_t           state, state_nxt;
    logic [TMR_W-1:0]     timer, timer_nxt;
    logic [IDX_W-1:0]     lane_idx, lane_idx_nxt;
    logic [NUM_LANES-1:0] lane_rst, lane_rst_nxt;
    logic                 ready, ready_nxt;
    logic                 timeout, timeout_nxt;
    logic                 lock_s;
    logic                 lock_lost;
    logic                 loss_evt;

    txpll_lock_sync u_lock_sync (
        .clk (Clock),
        .rst (Reset),
        .d   (PLL_LOCK),
        .q   (lock_s)
    );

    assign lock_lost = !lock_s &&
                       (state == ST_RELEASE || state == ST_READY);

    always_comb begin
        state_nxt    = state;
        timer_nxt    = timer;
        lane_idx_nxt = lane_idx;
        lane_rst_nxt = lane_rst;
        ready_nxt    = ready;
        timeout_nxt  = timeout;
        loss_evt     = 1'b0;

        if (!Enable) begin
            state_nxt    = ST_IDLE;
            timer_nxt    = '0;
            lane_idx_nxt = '0;
            lane_rst_nxt = ALL_RST;
            ready_nxt    = 1'b0;
            timeout_nxt  = 1'b0;
        end else if (lock_lost) begin
            state_nxt    = ST_WAIT_LOCK;
            timer_nxt    = '0;
            lane_idx_nxt = '0;
            lane_rst_nxt = ALL_RST;
            ready_nxt    = 1'b0;
            loss_evt     = 1'b1;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    state_nxt = ST_WAIT_LOCK;
                    timer_nxt = '0;
                end
                ST_WAIT_LOCK: begin
                    if (lock_s) begin
                        state_nxt = ST_QUALIFY;
                        timer_nxt = '0;
                    end else if (timer == TO_LAST) begin
                        state_nxt   = ST_FAULT;
                        timer_nxt   = '0;
                        timeout_nxt = 1'b1;
                    end else begin
                        timer_nxt = timer + 1'b1;
                    end
                end
                ST_QUALIFY: begin
                    if (!lock_s) begin
                        state_nxt = ST_WAIT_LOCK;
                        timer_nxt = '0;
                    end else if (timer == QL_LAST) begin
                        state_nxt    = ST_RELEASE;
                        timer_nxt    = '0;
                        lane_idx_nxt = '0;
                    end else begin
                        timer_nxt = timer + 1'b1;
                    end
                end
                // Timer counts down between releases; zero means "release now".
                ST_RELEASE: begin
                    if (timer == '0) begin
                        lane_rst_nxt = lane_rst << 1;
                        if (lane_idx == LAST_IDX) begin
                            state_nxt = ST_READY;
                            ready_nxt = 1'b1;
                            timer_nxt = '0;
                        end else begin
                            lane_idx_nxt = lane_idx + 1'b1;
                            timer_nxt    = STAG_LD;
                        end
                    end else begin
                        timer_nxt = timer - 1'b1;
                    end
                end
                ST_READY: begin
                    lane_rst_nxt = '0;
                    ready_nxt    = 1'b1;
                end
                ST_FAULT: begin
                    if (Retry) begin
                        state_nxt   = ST_WAIT_LOCK;
                        timer_nxt   = '0;
                        timeout_nxt = 1'b0;
                    end
                end
                default: begin
                    state_nxt    = ST_IDLE;
                    timer_nxt    = '0;
                    lane_idx_nxt = '0;
                    lane_rst_nxt = ALL_RST;
                    ready_nxt    = 1'b0;
                    timeout_nxt  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state    <= ST_IDLE;
            timer    <= '0;
            lane_idx <= '0;
            lane_rst <= ALL_RST;
            ready    <= 1'b0;
            timeout  <= 1'b0;
        end else begin
            state    <= state_nxt;
            timer    <= timer_nxt;
            lane_idx <= lane_idx_nxt;
            lane_rst <= lane_rst_nxt;
            ready    <= ready_nxt;
            timeout  <= timeout_nxt;
        end
    end

    assign Lane_Reset   = lane_rst;
    assign Pll_Ready    = ready;
    assign Lock_Timeout = timeout;
    assign Seq_State    = state;

`ifdef TXPLL_SEQ_LOSS_CNT_EN
    logic [LOSS_CNT_W-1:0] loss_cnt;

    always_ff @(posedge Clock) begin
        if (Reset || Loss_Clear) begin
            loss_cnt <= '0;
        end else if (loss_evt && loss_cnt != LOSS_CNT_MAX) begin
            loss_cnt <= loss_cnt + 1'b1;
        end
    end

    assign Loss_Count = loss_cnt;
`else
    logic unused_loss;

    assign unused_loss = Loss_Clear ^ loss_evt;
    assign Loss_Count  = '0;
`endif

endmodule
